// File: rtl/snl_pkg.sv
// Shared types for the serial nibble loader: FSM state encoding and default word width.
// The optional parity stage is enabled with the PARITY_CHECK_EN macro.
package snl_pkg;

  localparam int SNL_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_LOAD   = 2'd3
  } snl_state_e;

endpackage

// File: rtl/snl_bit_counter.sv
// Accepted-bit counter for the loader; saturates at WIDTH and flags the final data bit.
module snl_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  count <= '0;
    else if (clr)                               count <= '0;
    else if (inc && (count != CW'(WIDTH)))      count <= count + 1'b1;
  end

  assign done = inc && (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_nibble_loader.sv
// Serial-to-parallel front end feeding an enabled D-register bank with a one-cycle load strobe.
// Defining PARITY_CHECK_EN adds an even-parity bit after each word and the frame_err strobe.
module serial_nibble_loader
  import snl_pkg::*;
#(
  parameter int WIDTH     = SNL_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  output logic [WIDTH-1:0] load_data,
  output logic             load_en,
  output logic             frame_err,
  output logic             busy
);

  snl_state_e       state, state_d;
  logic [WIDTH-1:0] sh, sh_next, word_d;
  logic             take, data_take, done, seq_clr;
  logic             load_set, err_set;

  assign s_ready   = (state != ST_LOAD);
  assign busy      = (state != ST_IDLE);
  // clear wins over a same-cycle accept, so the bit is never taken
  assign take      = s_valid && s_ready && !clear;
  assign data_take = take && ((state == ST_IDLE) || (state == ST_SHIFT));
  assign sh_next   = (MSB_FIRST != 0) ? {sh[WIDTH-2:0], s_bit} : {s_bit, sh[WIDTH-1:1]};
  assign seq_clr   = clear || (state == ST_LOAD) || ((state == ST_PARITY) && take);

  snl_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (seq_clr),
    .inc   (data_take),
    .done  (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          state <= ST_IDLE;
    else                state <= state_d;
  end

  always_comb begin
    state_d  = state;
    load_set = 1'b0;
    err_set  = 1'b0;
    word_d   = sh_next;
    case (state)
      ST_IDLE:  if (take) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (take && done) begin
`ifdef PARITY_CHECK_EN
          state_d = ST_PARITY;
`else
          state_d  = ST_LOAD;
          load_set = 1'b1;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PARITY: begin
        word_d = sh;
        if (take) begin
          if ((^sh ^ s_bit) == 1'b0) begin
            state_d  = ST_LOAD;
            load_set = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_set = 1'b1;
          end
        end
      end
`endif
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          sh <= '0;
    else if (seq_clr)   sh <= '0;
    else if (data_take) sh <= sh_next;
  end

  // load_data only moves on a good word; it survives clear and frame errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_data <= '0;
      load_en   <= 1'b0;
    end else begin
      load_en <= load_set;
      if (load_set) load_data <= word_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= err_set;
  end
`else
  assign frame_err = 1'b0;
  logic unused_err;
  assign unused_err = err_set;
`endif

endmodule

// File: tb/tb_serial_nibble_loader.sv
// Directed bench for serial_nibble_loader: MSB-first and LSB-first instances share stimulus.
// Honours PARITY_CHECK_EN by appending an even-parity bit to every frame.
module tb_serial_nibble_loader;

`ifdef PARITY_CHECK_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       reset, clear, s_valid, s_bit;
  logic       m_ready, m_en, m_err, m_busy;
  logic       l_ready, l_en, l_err, l_busy;
  logic [3:0] m_data, l_data;
  int         checks = 0, passed = 0;
  int         pulses_m = 0, pulses_l = 0;

  always #5 clk = ~clk;

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .clear(clear), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(m_ready), .load_data(m_data), .load_en(m_en), .frame_err(m_err), .busy(m_busy));

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .clear(clear), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(l_ready), .load_data(l_data), .load_en(l_en), .frame_err(l_err), .busy(l_busy));

  always @(posedge clk) begin
    #1;
    if (m_en) pulses_m++;
    if (l_en) pulses_l++;
  end

  task automatic send(input logic b);
    s_valid = 1'b1;
    s_bit   = b;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // data bits MSB of w first, then the even-parity bit when compiled in
  task automatic frame(input logic [3:0] w);
    logic [4:0] s;
    s = {w, ^w};
    for (int i = 0; i < NB; i++) send(s[4-i]);
  endtask

  task automatic test_reset;
    reset = 1'b1; clear = 1'b0; s_valid = 1'b0; s_bit = 1'b0;
    #1;
    checks++; if (m_data !== 4'h0) $display("FAIL rst_data got %h want 0", m_data); else passed++;
    checks++; if (m_en !== 1'b0)   $display("FAIL rst_en got %b want 0", m_en); else passed++;
    checks++; if (m_err !== 1'b0)  $display("FAIL rst_err got %b want 0", m_err); else passed++;
    checks++; if (m_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", m_busy); else passed++;
    checks++; if (m_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", m_ready); else passed++;
    checks++; if (l_data !== 4'h0) $display("FAIL rst_ldata got %h want 0", l_data); else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    int p0m, p0l;
    @(posedge clk); #1;
    p0m = pulses_m; p0l = pulses_l;
    frame(4'b1011);
    checks++; if (m_en !== 1'b1)    $display("FAIL b2b_en got %b want 1", m_en); else passed++;
    checks++; if (m_data !== 4'hB)  $display("FAIL b2b_msb_data got %h want b", m_data); else passed++;
    checks++; if (l_data !== 4'hD)  $display("FAIL b2b_lsb_data got %h want d", l_data); else passed++;
    checks++; if (m_ready !== 1'b0) $display("FAIL b2b_ready_load got %b want 0", m_ready); else passed++;
    @(posedge clk); #1;
    checks++; if (m_en !== 1'b0)    $display("FAIL b2b_en_after got %b want 0", m_en); else passed++;
    checks++; if (m_ready !== 1'b1) $display("FAIL b2b_ready_after got %b want 1", m_ready); else passed++;
    checks++; if (m_data !== 4'hB)  $display("FAIL b2b_hold got %h want b", m_data); else passed++;
    repeat (3) @(posedge clk); #1;
    checks++; if (pulses_m - p0m != 1) $display("FAIL b2b_msb_pulses got %0d want 1", pulses_m - p0m); else passed++;
    checks++; if (pulses_l - p0l != 1) $display("FAIL b2b_lsb_pulses got %0d want 1", pulses_l - p0l); else passed++;
  endtask

  task automatic test_stall;
    logic [4:0] s;
    s = {4'b0111, ^4'b0111};
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) begin
      send(s[4-i]);
      if (i < NB - 1) begin
        checks++; if (m_busy !== 1'b1) $display("FAIL stall_busy%0d got %b want 1", i, m_busy); else passed++;
        checks++; if (m_en !== 1'b0)   $display("FAIL stall_en%0d got %b want 0", i, m_en); else passed++;
        @(posedge clk); #1;
        checks++; if (m_busy !== 1'b1) $display("FAIL stall_gap_busy%0d got %b want 1", i, m_busy); else passed++;
      end
    end
    checks++; if (m_en !== 1'b1)   $display("FAIL stall_en_final got %b want 1", m_en); else passed++;
    checks++; if (m_data !== 4'h7) $display("FAIL stall_msb_data got %h want 7", m_data); else passed++;
    checks++; if (l_data !== 4'hE) $display("FAIL stall_lsb_data got %h want e", l_data); else passed++;
  endtask

  task automatic test_clear;
    int p0m;
    repeat (2) @(posedge clk); #1;
    p0m = pulses_m;
    send(1'b1); send(1'b0);
    clear = 1'b1; s_valid = 1'b1; s_bit = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; s_valid = 1'b0;
    checks++; if (m_busy !== 1'b0) $display("FAIL clr_busy got %b want 0", m_busy); else passed++;
    checks++; if (m_en !== 1'b0)   $display("FAIL clr_en got %b want 0", m_en); else passed++;
    checks++; if (m_data !== 4'h7) $display("FAIL clr_data_kept got %h want 7", m_data); else passed++;
    frame(4'b0110);
    checks++; if (m_en !== 1'b1)   $display("FAIL clr_load_en got %b want 1", m_en); else passed++;
    checks++; if (m_data !== 4'h6) $display("FAIL clr_msb_data got %h want 6", m_data); else passed++;
    checks++; if (l_data !== 4'h6) $display("FAIL clr_lsb_data got %h want 6", l_data); else passed++;
    repeat (3) @(posedge clk); #1;
    checks++; if (pulses_m - p0m != 1) $display("FAIL clr_pulses got %0d want 1", pulses_m - p0m); else passed++;
  endtask

  task automatic test_reset_mid;
    int p0m;
    @(posedge clk); #1;
    p0m = pulses_m;
    send(1'b1); send(1'b1); send(1'b0);
    #2 reset = 1'b1;
    #1;
    checks++; if (m_en !== 1'b0)    $display("FAIL rmid_en got %b want 0", m_en); else passed++;
    checks++; if (m_data !== 4'h0)  $display("FAIL rmid_data got %h want 0", m_data); else passed++;
    checks++; if (m_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", m_ready); else passed++;
    checks++; if (m_busy !== 1'b0)  $display("FAIL rmid_busy got %b want 0", m_busy); else passed++;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (pulses_m != p0m) $display("FAIL rmid_no_pulse got %0d want %0d", pulses_m, p0m); else passed++;
    frame(4'b1100);
    checks++; if (m_en !== 1'b1)   $display("FAIL rmid_load_en got %b want 1", m_en); else passed++;
    checks++; if (m_data !== 4'hC) $display("FAIL rmid_msb_data got %h want c", m_data); else passed++;
    checks++; if (l_data !== 4'h3) $display("FAIL rmid_lsb_data got %h want 3", l_data); else passed++;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity;
    repeat (2) @(posedge clk); #1;
    send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b1);
    checks++; if (m_en !== 1'b1)   $display("FAIL par_good_en got %b want 1", m_en); else passed++;
    checks++; if (m_err !== 1'b0)  $display("FAIL par_good_err got %b want 0", m_err); else passed++;
    checks++; if (m_data !== 4'hB) $display("FAIL par_good_data got %h want b", m_data); else passed++;
    repeat (2) @(posedge clk); #1;
    send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    checks++; if (m_err !== 1'b1)  $display("FAIL par_bad_err got %b want 1", m_err); else passed++;
    checks++; if (m_en !== 1'b0)   $display("FAIL par_bad_en got %b want 0", m_en); else passed++;
    checks++; if (m_data !== 4'hB) $display("FAIL par_bad_data got %h want b", m_data); else passed++;
    @(posedge clk); #1;
    checks++; if (m_err !== 1'b0)  $display("FAIL par_err_len got %b want 0", m_err); else passed++;
    checks++; if (m_busy !== 1'b0) $display("FAIL par_err_idle got %b want 0", m_busy); else passed++;
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_stall;
    test_clear;
    test_reset_mid;
`ifdef PARITY_CHECK_EN
    test_parity;
`endif
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
